// File: rtl/canny_pkg.sv
// canny_pkg: shared definitions for the Canny streaming blocks (Sobel, NMS and
// hysteresis stages).
//   DIR_*        quantised edge-normal direction codes carried on out_dir
//   grad_width() signed width of a 3x3 Sobel gradient for a given pixel width
package canny_pkg;

    localparam logic [1:0] DIR_0   = 2'd0;
    localparam logic [1:0] DIR_45  = 2'd1;
    localparam logic [1:0] DIR_90  = 2'd2;
    localparam logic [1:0] DIR_135 = 2'd3;

    // A Sobel tap sum spans +/- 4*(2^dw - 1), which needs three extra bits
    // including the sign.
    function automatic int grad_width(input int data_width);
        return data_width + 3;
    endfunction

endpackage

// File: rtl/canny_line_buffer.sv
// canny_line_buffer: one-line delay for a raster stream.
// Each enabled cycle the word stored DEPTH enables ago appears on dout_o
// and din_i takes its place in the same location (read-before-write on a
// single pointer). Memory contents are not reset; only the pointer is.
//   clk     clock
//   rst_b   synchronous active-low reset (pointer only)
//   en_i    advance the delay line by one word
//   din_i   word entering the delay
//   dout_o  word written DEPTH enables earlier
module canny_line_buffer
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (en_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[ptr_q] <= din_i;
        end
    end

    assign dout_o = mem_q[ptr_q];

endmodule

// File: rtl/canny_sobel_stream.sv
// canny_sobel_stream: streaming 3x3 Sobel stage.
// Builds a 3x3 window from two cascaded line buffers plus two registered
// columns, and for every complete window produces a saturated gradient
// magnitude and a 2-bit quantised edge-normal direction. Two enabled cycles
// from the completing pixel to out_valid; whole pipeline stalls on
// out_valid && !out_ready.
//   clk, rst_b          clock, synchronous active-low reset
//   in_valid/in_ready   pixel handshake (in_ready = pipeline enable)
//   in_sof              first pixel of a frame; resyncs counters to (0,0)
//   in_pixel            unsigned pixel, raster order
//   out_valid/out_ready result handshake
//   out_eof             last interior result of the frame
//   out_mag, out_dir    magnitude and direction (DIR_0..DIR_135)
module canny_sobel_stream
    import canny_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 64,
    parameter int IMG_HEIGHT = 64,
    parameter int MAG_SHIFT  = 3
) (
    input  logic                  clk,
    input  logic                  rst_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [DATA_WIDTH-1:0] in_pixel,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eof,
    output logic [DATA_WIDTH-1:0] out_mag,
    output logic [1:0]            out_dir
);

    localparam int GW  = grad_width(DATA_WIDTH);
    localparam int DW2 = GW + 4;  // room for 5*Gx in the direction compares
    localparam int CW  = $clog2(IMG_WIDTH);
    localparam int RW  = $clog2(IMG_HEIGHT);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [GW:0]   MAG_MAX  = {{(GW + 1 - DATA_WIDTH){1'b0}}, {DATA_WIDTH{1'b1}}};

    // ---------------------------------------------------------------- control
    logic en, accept, win_full, last_px;
    logic [1:0] vld_pipe_q;

    assign en        = !out_valid || out_ready;
    assign in_ready  = en;
    assign accept    = in_valid && en;
    assign out_valid = vld_pipe_q[1];

    // ---------------------------------------------------------------- counters
    // in_sof overrides the stored position before the pixel is used.
    logic [CW-1:0] col_q, col_d, col_cur;
    logic [RW-1:0] row_q, row_d, row_cur;

    always_comb begin
        col_cur = in_sof ? '0 : col_q;
        row_cur = in_sof ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        if (accept) begin
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = (row_cur == ROW_LAST) ? '0 : row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign win_full = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
    assign last_px  = (row_cur == ROW_LAST) && (col_cur == COL_LAST);

    // ---------------------------------------------------------------- window
    // Incoming column: top = two lines back, mid = one line back, bot = now.
    logic [DATA_WIDTH-1:0] lb_mid, lb_top;
    logic [DATA_WIDTH-1:0] new_col [3];
    logic [DATA_WIDTH-1:0] win_q   [3][2];  // [row][0] = col-2, [row][1] = col-1

    canny_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_mid (
        .clk    (clk),
        .rst_b  (rst_b),
        .en_i   (accept),
        .din_i  (in_pixel),
        .dout_o (lb_mid)
    );

    canny_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_lb_top (
        .clk    (clk),
        .rst_b  (rst_b),
        .en_i   (accept),
        .din_i  (lb_mid),
        .dout_o (lb_top)
    );

    assign new_col[0] = lb_top;
    assign new_col[1] = lb_mid;
    assign new_col[2] = in_pixel;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= new_col[r];
            end
        end
    end

    // ---------------------------------------------------------------- stage 1
    // The third window column is the incoming one, so the gradient of the
    // completing pixel is registered at its own acceptance edge.
    logic signed [GW-1:0] p [3][3];
    logic signed [GW-1:0] gx_d, gy_d, gx_q, gy_q;
    logic                 eof1_q;

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            p[r][0] = GW'(win_q[r][0]);
            p[r][1] = GW'(win_q[r][1]);
            p[r][2] = GW'(new_col[r]);
        end
        gx_d = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
        gy_d = (p[0][0] + (p[0][1] <<< 1) + p[0][2]) - (p[2][0] + (p[2][1] <<< 1) + p[2][2]);
    end

    // ---------------------------------------------------------------- stage 2
    logic [GW-1:0]         abs_gx, abs_gy;
    logic [GW:0]           mag_sum, mag_shr;
    logic [DATA_WIDTH-1:0] mag_d, mag_q;
    logic [1:0]            dir_d, dir_q;
    logic                  eof2_q;
    logic signed [DW2-1:0] gxn, gyn, two_gy, five_gx;

    always_comb begin
        abs_gx  = gx_q[GW-1] ? -gx_q : gx_q;
        abs_gy  = gy_q[GW-1] ? -gy_q : gy_q;
        mag_sum = {1'b0, abs_gx} + {1'b0, abs_gy};
        mag_shr = mag_sum >> MAG_SHIFT;
        mag_d   = (mag_shr > MAG_MAX) ? '1 : mag_shr[DATA_WIDTH-1:0];

        // Fold the lower half-plane onto the upper one so only 0..180 deg
        // remains; tan(22.5) ~ 1/2 and tan(67.5) ~ 5/2 give the bin edges.
        gxn = DW2'(gx_q);
        gyn = DW2'(gy_q);
        if (gy_q[GW-1]) begin
            gxn = -gxn;
            gyn = -gyn;
        end
        two_gy  = gyn <<< 1;
        five_gx = (gxn <<< 2) + gxn;
        dir_d   = DIR_90;
        if (!gxn[DW2-1]) begin
            if (two_gy <= gxn)          dir_d = DIR_0;
            else if (two_gy <= five_gx) dir_d = DIR_45;
        end else begin
            if (two_gy <= -gxn)          dir_d = DIR_0;
            else if (two_gy <= -five_gx) dir_d = DIR_135;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            vld_pipe_q <= '0;
            gx_q       <= '0;
            gy_q       <= '0;
            eof1_q     <= 1'b0;
            mag_q      <= '0;
            dir_q      <= '0;
            eof2_q     <= 1'b0;
        end else if (en) begin
            vld_pipe_q <= {vld_pipe_q[0], accept && win_full};
            gx_q       <= gx_d;
            gy_q       <= gy_d;
            eof1_q     <= accept && win_full && last_px;
            mag_q      <= mag_d;
            dir_q      <= dir_d;
            eof2_q     <= vld_pipe_q[0] && eof1_q;
        end
    end

    assign out_mag = mag_q;
    assign out_dir = dir_q;
    assign out_eof = eof2_q;

endmodule

// File: tb/tb_canny_sobel_stream.sv
// Bench for canny_sobel_stream on an 8x6 frame. Two instances share the input
// stream: one with MAG_SHIFT=3, one with MAG_SHIFT=0 (saturation). A
// frame-image model computes every expected result from the Sobel rules;
// directed frames additionally pin hand-computed values.
module tb_canny_sobel_stream;

    localparam int W = 8;
    localparam int H = 6;
    localparam int NRES = (W - 2) * (H - 2);

    logic       clk = 1'b0;
    logic       rst_b;
    logic       in_valid, in_sof, out_ready;
    logic [7:0] in_pixel;
    logic       in_ready, out_valid, out_eof;
    logic [7:0] out_mag;
    logic [1:0] out_dir;
    logic       in_ready0, out_valid0, out_eof0;
    logic [7:0] out_mag0;
    logic [1:0] out_dir0;

    canny_sobel_stream #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_SHIFT(3)) dut (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid), .out_ready(out_ready), .out_eof(out_eof),
        .out_mag(out_mag), .out_dir(out_dir));

    canny_sobel_stream #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_SHIFT(0)) dut_s0 (
        .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready0), .in_sof(in_sof),
        .in_pixel(in_pixel), .out_valid(out_valid0), .out_ready(out_ready), .out_eof(out_eof0),
        .out_mag(out_mag0), .out_dir(out_dir0));

    always #5 clk = ~clk;

    typedef struct { int mag3; int mag0; int dir; int eof; } res_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   rdy_pct = 100;
    res_t exp_q[$];
    res_t got_q[$];
    int   img [H][W];
    int   mrow = 0, mcol = 0;
    bit   held_v = 0;
    int   held_mag, held_dir, held_eof;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int model_mag(input int gx, input int gy, input int sh);
        int s;
        s = ((gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy)) >> sh;
        return (s > 255) ? 255 : s;
    endfunction

    function automatic int model_dir(input int gx_in, input int gy_in);
        int gx, gy;
        gx = gx_in; gy = gy_in;
        if (gy < 0) begin gx = -gx; gy = -gy; end
        if (gx >= 0) begin
            if (2 * gy <= gx) return 0;
            if (2 * gy <= 5 * gx) return 1;
            return 2;
        end
        if (2 * gy <= -gx) return 0;
        if (2 * gy <= -5 * gx) return 3;
        return 2;
    endfunction

    // Monitor + scoreboard: all sampling on the falling edge.
    always @(negedge clk) begin
        res_t e;
        int gx, gy, r, c;
        if (!rst_b) begin
            exp_q.delete();
            mrow = 0; mcol = 0; held_v = 0;
        end else begin
            if (held_v) begin
                chk("stall_valid", int'(out_valid), 1);
                chk("stall_mag", int'(out_mag), held_mag);
                chk("stall_dir", int'(out_dir), held_dir);
                chk("stall_eof", int'(out_eof), held_eof);
                held_v = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL unexpected_out: got result mag=%0d with none expected (t=%0t)", out_mag, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mag", int'(out_mag), e.mag3);
                    chk("mag_s0", int'(out_mag0), e.mag0);
                    chk("valid_s0", int'(out_valid0), 1);
                    chk("dir", int'(out_dir), e.dir);
                    chk("eof", int'(out_eof), e.eof);
                    got_q.push_back('{int'(out_mag), int'(out_mag0), int'(out_dir), int'(out_eof)});
                end
            end else if (out_valid) begin
                held_v = 1;
                held_mag = out_mag; held_dir = out_dir; held_eof = out_eof;
            end
            if (in_valid && in_ready) begin
                if (in_sof) begin mrow = 0; mcol = 0; end
                r = mrow; c = mcol;
                img[r][c] = in_pixel;
                if (r >= 2 && c >= 2) begin
                    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c]) - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
                    gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]) - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
                    exp_q.push_back('{model_mag(gx, gy, 3), model_mag(gx, gy, 0), model_dir(gx, gy),
                                      int'(r == H-1 && c == W-1)});
                end
                if (mcol == W-1) begin
                    mcol = 0;
                    mrow = (mrow == H-1) ? 0 : mrow + 1;
                end else begin
                    mcol++;
                end
            end
        end
    end

    // Downstream back-pressure.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int cyc);
        rst_b = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
        repeat (cyc) @(posedge clk);
        #1 rst_b = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_eof", int'(out_eof), 0);
        chk("rst_out_mag", int'(out_mag), 0);
        chk("rst_out_dir", int'(out_dir), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_in_ready_s0", int'(in_ready0), 1);
        @(posedge clk); #1;
    endtask

    task automatic push_pix(input int pix, input bit sof);
        bit acc;
        int guard;
        guard = 0;
        in_valid = 1'b1; in_pixel = 8'(pix); in_sof = sof;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
        end while (!acc && guard < 1000);
        if (!acc) chk("accept_timeout", 0, 1);
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    function automatic int pat(input int id, input int r, input int c);
        case (id)
            0:       return 50;
            1:       return (c < 4) ? 0 : 80;
            2:       return (r < 3) ? 80 : 0;
            3:       return (r == 2 && c == 5) ? 100 : 0;
            default: return ((c >> 1) & 1) ? 255 : 0;
        endcase
    endfunction

    task automatic run_frame(input int id);
        int guard, r, c;
        got_q.delete();
        for (int rr = 0; rr < H; rr++)
            for (int cc = 0; cc < W; cc++)
                push_pix(pat(id, rr, cc), rr == 0 && cc == 0);
        guard = 0;
        while (got_q.size() < NRES && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("frame_results", got_q.size(), NRES);
        if (got_q.size() == NRES) begin
            for (int k = 0; k < NRES; k++) begin
                r = k / (W - 2) + 1;
                c = k % (W - 2) + 1;
                case (id)
                    0: begin
                        chk("flat_mag", got_q[k].mag3, 0);
                        chk("flat_dir", got_q[k].dir, 0);
                        chk("flat_eof", got_q[k].eof, (k == NRES-1) ? 1 : 0);
                    end
                    1: begin
                        chk("vstep_mag", got_q[k].mag3, (c == 3 || c == 4) ? 40 : 0);
                        chk("vstep_dir", got_q[k].dir, 0);
                    end
                    2: begin
                        chk("hstep_mag", got_q[k].mag3, (r == 2 || r == 3) ? 40 : 0);
                        chk("hstep_dir", got_q[k].dir, (r == 2 || r == 3) ? 2 : 0);
                    end
                    3: if (r == 3 && c == 4) begin
                        chk("diag_mag", got_q[k].mag3, 25);
                        chk("diag_dir", got_q[k].dir, 1);
                    end
                    default: begin
                        chk("stripe_sat_mag", got_q[k].mag0, 255);
                        chk("stripe_mag_sh3", got_q[k].mag3, 127);
                        chk("stripe_dir", got_q[k].dir, 0);
                    end
                endcase
            end
        end
    endtask

    initial begin
        int guard;
        bit sof;
        rst_b = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0;
        do_reset(3);

        rdy_pct = 100;
        run_frame(0);
        rdy_pct = 60;
        for (int id = 1; id <= 4; id++) run_frame(id);

        // Random stream with back-pressure, gaps, mid-frame sof and reset.
        for (int i = 0; i < 400; i++) begin
            if (i == 230) do_reset(2);
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            sof = (i == 0) || (i == 100) || ($urandom_range(0, 59) == 0);
            push_pix($urandom_range(0, 255), sof);
        end

        rdy_pct = 100;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/canny_sobel_stream.md
Name: canny_sobel_stream

Overview:
- Streaming successor to the window-register edge engine.
- Accepts a raster pixel stream and builds a 3x3 window from two internal line buffers.
- Each cycle, computes the Sobel gradient magnitude and the quantised edge-normal direction for every interior pixel.
- Sits between the streaming Gaussian stage and the NMS stage; outputs one result per interior pixel under valid/ready flow control.

Parameters:
DATA_WIDTH, 8, pixel and magnitude width in bits
IMG_WIDTH, 64, pixels per line (minimum 3)
IMG_HEIGHT, 64, lines per frame (minimum 3)
MAG_SHIFT, 3, right shift applied to |Gx|+|Gy| before saturation

Ports:
clk  in  1  clock, all logic on rising edge
rst_b  in  1  reset, synchronous, active-low
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts a pixel this cycle
in_sof  in  1  accompanies first pixel of a frame
in_pixel  in  DATA_WIDTH  unsigned pixel, raster order
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_eof  out  1  marks last interior result of frame
out_mag  out  DATA_WIDTH  saturated gradient magnitude
out_dir  out  2  0=0deg, 1=45deg, 2=90deg, 3=135deg

Behaviour:
- Reset (rst_b low at a clk edge):
  - col/row counters cleared to 0.
  - Line buffer read/write pointers cleared to 0; RAM contents are not cleared.
  - Pipeline valids cleared; out_valid=0, out_eof=0, out_mag=0, out_dir=0.
  - in_ready=1 in the first cycle after reset releases.
  - Reset mid-frame discards all in-flight data; the next accepted pixel is treated as (0,0) whether or not in_sof is asserted.
- Acceptance:
  - A pixel is accepted when in_valid && in_ready.
  - Pipeline enable: en = !out_valid || out_ready.
  - in_ready = en (combinational).
  - When en=0, all stages, counters and line buffers hold their values.
- Counters:
  - col increments per accepted pixel and wraps to 0 at IMG_WIDTH-1; row increments on that wrap.
  - The frame ends after pixel (IMG_HEIGHT-1, IMG_WIDTH-1); counters then return to (0,0).
  - An accepted pixel with in_sof=1 forces counters to (0,0) before that pixel is used, even mid-frame; stage results already in flight still drain.
- Window:
  - Two line buffers, each IMG_WIDTH deep, plus a 3x3 shift window of registers.
  - The window is complete when the accepted pixel has row>=2 and col>=2; its centre is (row-1, col-1).
  - Only complete windows produce output, so each frame yields (IMG_HEIGHT-2)*(IMG_WIDTH-2) results. Border pixels produce nothing.
- Stage 1 (registered), signed, width DATA_WIDTH+3:
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20).
  - Gy = (p00 + 2*p01 + p02) - (p20 + 2*p21 + p22), with row 0 = top.
- Stage 2 (registered output):
  - Magnitude: s = (|Gx|+|Gy|) >> MAG_SHIFT; out_mag = min(s, 2^DATA_WIDTH-1).
  - Direction: if Gy<0, negate both Gx and Gy (giving Gx', Gy'). Then, with integer compares only:
    - Gx'>=0: 2*Gy'<=Gx' -> 0; 2*Gy'<=5*Gx' -> 1; else -> 2.
    - Gx'<0: 2*Gy'<=-Gx' -> 0; 2*Gy'<=-5*Gx' -> 3; else -> 2.
    - Gx=Gy=0 gives 0.
- Latency: 2 enabled cycles from acceptance of the completing pixel to out_valid.
- out_eof=1 with the result whose centre is (IMG_HEIGHT-2, IMG_WIDTH-2).
- Out-of-range MAG_SHIFT or DATA_WIDTH combinations are not legal; saturation covers every legal setting.
- The output holds stable while out_valid && !out_ready.

Decomposition:
- canny_pkg:
  - DIR_0/DIR_45/DIR_90/DIR_135 localparams.
  - Gradient width function (DATA_WIDTH+3).
  - Shared with the NMS and hysteresis stream blocks.
- Sub-module canny_line_buffer: a single-port, IMG_WIDTH-deep, DATA_WIDTH-wide row delay with an enable. It is instantiated twice and cascaded.

Test Plan:
- 8x6 frame, all pixels 50 -> 24 results, all out_mag=0, out_dir=0; out_eof only on the 24th.
- 8x6 frame, cols 0-3 =0, cols 4-7 =80 -> centres at col 3 and col 4: Gx=320, out_mag=40, out_dir=0; all other centres 0.
- 8x6 frame, rows 0-2 =80, rows 3-5 =0 -> centres at row 2 and row 3: Gy=320, out_mag=40, out_dir=2.
- 8x6 frame, all 0 except pixel (2,5)=100 -> centre (3,4): Gx=100, Gy=100, out_mag=25, out_dir=1.
- MAG_SHIFT=0, alternating column stripes of 0/255 -> interior |Gx|=1020, out_mag saturates to 255.
- Random out_ready (~40% low), in_sof reasserted mid-frame, and reset asserted mid-frame -> no result lost, duplicated or changed while stalled; the counter resync and the reset restart each match the reference model.
